// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with a single-outstanding req/ack data bus.
// It aligns and extends load data, builds store byte enables, raises a
// stall while a bus transaction is in flight, and reports access faults.

`ifndef PORT_ADDR_WIDTH
`define PORT_ADDR_WIDTH 32
`endif
`ifndef PORT_DATA_WIDTH
`define PORT_DATA_WIDTH 32
`endif

module mem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mem_lsu_valid_i,
  input  logic                        mem_lsu_load_i,
  input  logic                        mem_lsu_store_i,
  input  logic [2:0]                  mem_lsu_funct3_i,
  input  logic [`PORT_ADDR_WIDTH-1:0] mem_lsu_addr_i,
  input  logic [`PORT_DATA_WIDTH-1:0] mem_lsu_wdata_i,
  input  logic [4:0]                  mem_lsu_rd_i,
  input  logic [`PORT_ADDR_WIDTH-1:0] mem_lsu_pc_i,
  input  logic                        mem_lsu_flush_i,
  output logic                        dbus_req_o,
  output logic                        dbus_we_o,
  output logic [`PORT_ADDR_WIDTH-1:0] dbus_addr_o,
  output logic [`PORT_DATA_WIDTH-1:0] dbus_wdata_o,
  output logic [3:0]                  dbus_be_o,
  input  logic                        dbus_ack_i,
  input  logic [`PORT_DATA_WIDTH-1:0] dbus_rdata_i,
  output logic                        mem_lsu_wb_valid_o,
  output logic [4:0]                  mem_lsu_wb_rd_o,
  output logic [`PORT_DATA_WIDTH-1:0] mem_lsu_wb_data_o,
  output logic                        mem_lsu_stall_o,
  output logic                        mem_lsu_exc_o,
  output logic [1:0]                  mem_lsu_exc_cause_o,
  output logic [`PORT_ADDR_WIDTH-1:0] mem_lsu_exc_pc_o
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t                        state, state_next;
  logic                          mem_op, legal, aligned, accept, exc_idle;
  logic                          timeout, ack_done;
  logic [15:0]                   tmo_cnt;
  logic [2:0]                    lat_funct3;
  logic [1:0]                    lat_off;
  logic [4:0]                    lat_rd;
  logic [`PORT_ADDR_WIDTH-1:0]   lat_pc;
  logic [3:0]                    st_be;
  logic [`PORT_DATA_WIDTH-1:0]   st_wdata;
  logic [7:0]                    rd_byte;
  logic [15:0]                   rd_half;
  logic [`PORT_DATA_WIDTH-1:0]   load_data;

  // Classify the EX/MEM instruction: legality, alignment, accept or fault.
  always_comb begin
    mem_op  = mem_lsu_valid_i & (mem_lsu_load_i | mem_lsu_store_i) & ~mem_lsu_flush_i;
    legal   = 1'b0;
    aligned = 1'b1;
    if (mem_lsu_load_i) begin
      case (mem_lsu_funct3_i)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end else if (mem_lsu_store_i) begin
      case (mem_lsu_funct3_i)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        default:                legal = 1'b0;
      endcase
    end
    case (mem_lsu_funct3_i[1:0])
      2'b01:   aligned = ~mem_lsu_addr_i[0];
      2'b10:   aligned = (mem_lsu_addr_i[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    accept   = (state == IDLE) & mem_op & legal & aligned;
    exc_idle = (state == IDLE) & mem_op & ~(legal & aligned);
  end

  // Build the lane-shifted store data and byte enables for the bus.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = mem_lsu_wdata_i;
    if (mem_lsu_store_i) begin
      case (mem_lsu_funct3_i)
        3'b000: begin
          st_be    = 4'b0001 << mem_lsu_addr_i[1:0];
          st_wdata = {4{mem_lsu_wdata_i[7:0]}};
        end
        3'b001: begin
          st_be    = 4'b0011 << mem_lsu_addr_i[1:0];
          st_wdata = {2{mem_lsu_wdata_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Pick the addressed lane from the read word and sign/zero-extend it.
  always_comb begin
    case (lat_off)
      2'd0:    rd_byte = dbus_rdata_i[7:0];
      2'd1:    rd_byte = dbus_rdata_i[15:8];
      2'd2:    rd_byte = dbus_rdata_i[23:16];
      default: rd_byte = dbus_rdata_i[31:24];
    endcase
    rd_half = lat_off[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
    case (lat_funct3)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_data = {24'h0, rd_byte};
      3'b101:  load_data = {16'h0, rd_half};
      default: load_data = dbus_rdata_i;
    endcase
  end

  // State register; reset drops req immediately since req decodes the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: leave IDLE on accept, leave REQ on ack or timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = REQ;
      REQ:     if (dbus_ack_i || timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: bus request, completion/timeout strobes and upstream stall.
  always_comb begin
    dbus_req_o      = (state == REQ);
    ack_done        = (state == REQ) & dbus_ack_i;
    timeout         = (state == REQ) & ~dbus_ack_i & (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
    mem_lsu_stall_o = accept | ((state == REQ) & ~dbus_ack_i & ~timeout);
  end

  // Latch the accepted access, count REQ cycles, register writeback and faults.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbus_we_o           <= 1'b0;
      dbus_addr_o         <= '0;
      dbus_wdata_o        <= '0;
      dbus_be_o           <= 4'b0000;
      lat_funct3          <= 3'b000;
      lat_off             <= 2'b00;
      lat_rd              <= 5'd0;
      lat_pc              <= '0;
      tmo_cnt             <= 16'd0;
      mem_lsu_wb_valid_o  <= 1'b0;
      mem_lsu_wb_rd_o     <= 5'd0;
      mem_lsu_wb_data_o   <= '0;
      mem_lsu_exc_o       <= 1'b0;
      mem_lsu_exc_cause_o <= 2'b00;
      mem_lsu_exc_pc_o    <= '0;
    end else begin
      if (accept) begin
        dbus_we_o    <= mem_lsu_store_i;
        dbus_addr_o  <= {mem_lsu_addr_i[`PORT_ADDR_WIDTH-1:2], 2'b00};
        dbus_wdata_o <= st_wdata;
        dbus_be_o    <= st_be;
        lat_funct3   <= mem_lsu_funct3_i;
        lat_off      <= mem_lsu_addr_i[1:0];
        lat_rd       <= mem_lsu_rd_i;
        lat_pc       <= mem_lsu_pc_i;
        tmo_cnt      <= 16'd0;
      end else if ((state == REQ) && !dbus_ack_i && !timeout) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
      mem_lsu_wb_valid_o <= ack_done & ~dbus_we_o;
      if (ack_done && !dbus_we_o) begin
        mem_lsu_wb_rd_o   <= lat_rd;
        mem_lsu_wb_data_o <= load_data;
      end
      mem_lsu_exc_o <= exc_idle | timeout;
      if (exc_idle) begin
        mem_lsu_exc_cause_o <= legal ? 2'b01 : 2'b10;
        mem_lsu_exc_pc_o    <= mem_lsu_pc_i;
      end else if (timeout) begin
        mem_lsu_exc_cause_o <= 2'b11;
        mem_lsu_exc_pc_o    <= lat_pc;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed bench for mem_lsu with writeback/exception scoreboards.

module tb_mem_lsu;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  typedef struct packed {
    logic [1:0]  cause;
    logic [31:0] pc;
  } exc_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, load, store, flush;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, pc;
  logic [4:0]  rd;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic        wb_valid, stall, exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_pc;
  logic [1:0]  exc_cause;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int last_wb_cycle = 0;
  int prev_wb_cycle = 0;
  wb_exp_t  wbq[$];
  exc_exp_t excq[$];

  mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .mem_lsu_valid_i     (valid),
    .mem_lsu_load_i      (load),
    .mem_lsu_store_i     (store),
    .mem_lsu_funct3_i    (funct3),
    .mem_lsu_addr_i      (addr),
    .mem_lsu_wdata_i     (wdata),
    .mem_lsu_rd_i        (rd),
    .mem_lsu_pc_i        (pc),
    .mem_lsu_flush_i     (flush),
    .dbus_req_o          (dbus_req),
    .dbus_we_o           (dbus_we),
    .dbus_addr_o         (dbus_addr),
    .dbus_wdata_o        (dbus_wdata),
    .dbus_be_o           (dbus_be),
    .dbus_ack_i          (dbus_ack),
    .dbus_rdata_i        (dbus_rdata),
    .mem_lsu_wb_valid_o  (wb_valid),
    .mem_lsu_wb_rd_o     (wb_rd),
    .mem_lsu_wb_data_o   (wb_data),
    .mem_lsu_stall_o     (stall),
    .mem_lsu_exc_o       (exc),
    .mem_lsu_exc_cause_o (exc_cause),
    .mem_lsu_exc_pc_o    (exc_pc)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic ld, input logic st,
                                input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [4:0] r,
                                input logic [31:0] p, input logic fl);
    valid  = v;
    load   = ld;
    store  = st;
    funct3 = f3;
    addr   = a;
    wdata  = wd;
    rd     = r;
    pc     = p;
    flush  = fl;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic take_wb();
    wb_exp_t e;
    check_output("wb_valid", {31'h0, wb_valid}, 32'h1);
    if (wbq.size() > 0) begin
      e = wbq.pop_front();
      check_output("wb_data", wb_data, e.data);
      check_output("wb_rd", {27'h0, wb_rd}, {27'h0, e.rd});
      prev_wb_cycle = last_wb_cycle;
      last_wb_cycle = cycle;
    end else begin
      checks++;
      failures++;
      $error("[TB] FAIL wb_unexpected observed data=0x%08h expected no writeback", wb_data);
    end
  endtask

  task automatic pop_wb(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (wb_valid) seen = 1'b1;
      else next_cycle();
    end
    if (seen) take_wb();
    else begin
      checks++;
      failures++;
      $error("[TB] FAIL wb_wait observed no wb_valid expected pulse within %0d cycles", budget);
    end
  endtask

  task automatic pop_exc(input int budget);
    bit seen = 1'b0;
    exc_exp_t e;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (exc) seen = 1'b1;
      else next_cycle();
    end
    if (seen && excq.size() > 0) begin
      e = excq.pop_front();
      check_output("exc_cause", {30'h0, exc_cause}, {30'h0, e.cause});
      check_output("exc_pc", exc_pc, e.pc);
    end else begin
      checks++;
      failures++;
      $error("[TB] FAIL exc_wait observed exc=%0b queued=%0d expected one pulse", exc, excq.size());
    end
  endtask

  // One accepted access: accept at N, ack after ack_delay extra REQ cycles.
  task automatic run_access(input logic is_load, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [4:0] r, input logic [31:0] p,
                            input int ack_delay, input logic [31:0] rdata,
                            input logic flush_in_req, input logic pop_prev,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
    apply_stimulus(1'b1, is_load, ~is_load, f3, a, wd, r, p, 1'b0);
    @(negedge clk);
    if (pop_prev) take_wb();
    check_output("accept_stall", {31'h0, stall}, 32'h1);
    check_output("accept_req_low", {31'h0, dbus_req}, 32'h0);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0, flush_in_req);
    for (int i = 0; i <= ack_delay; i++) begin
      if (i == ack_delay) begin
        dbus_ack   = 1'b1;
        dbus_rdata = rdata;
      end
      @(negedge clk);
      check_output("req_high", {31'h0, dbus_req}, 32'h1);
      check_output("bus_addr", dbus_addr, exp_addr);
      check_output("bus_be", {28'h0, dbus_be}, {28'h0, exp_be});
      check_output("bus_we", {31'h0, dbus_we}, {31'h0, ~is_load});
      if (!is_load) check_output("bus_wdata", dbus_wdata, exp_wdata);
      check_output("req_stall", {31'h0, stall}, {31'h0, (i != ack_delay)});
      next_cycle();
    end
    dbus_ack   = 1'b0;
    dbus_rdata = 32'h0;
    flush      = 1'b0;
  endtask

  // Illegal or misaligned access seen in IDLE: registered exception, no bus.
  task automatic do_exc(input logic is_load, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] p,
                        input logic [1:0] exp_cause);
    excq.push_back('{cause: exp_cause, pc: p});
    apply_stimulus(1'b1, is_load, ~is_load, f3, a, 32'hA5A5_A5A5, 5'd1, p, 1'b0);
    @(negedge clk);
    check_output("exc_no_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    pop_exc(1);
    check_output("exc_no_req", {31'h0, dbus_req}, 32'h0);
    next_cycle();
    @(negedge clk);
    check_output("exc_pulse_end", {31'h0, exc}, 32'h0);
    next_cycle();
  endtask

  // Directed sequence.
  initial begin
    rst_n      = 1'b0;
    dbus_ack   = 1'b0;
    dbus_rdata = 32'h0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);

    @(negedge clk);
    check_output("rst_req", {31'h0, dbus_req}, 32'h0);
    check_output("rst_we", {31'h0, dbus_we}, 32'h0);
    check_output("rst_addr", dbus_addr, 32'h0);
    check_output("rst_wdata", dbus_wdata, 32'h0);
    check_output("rst_be", {28'h0, dbus_be}, 32'h0);
    check_output("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    check_output("rst_wb_rd", {27'h0, wb_rd}, 32'h0);
    check_output("rst_wb_data", wb_data, 32'h0);
    check_output("rst_exc", {31'h0, exc}, 32'h0);
    check_output("rst_cause", {30'h0, exc_cause}, 32'h0);
    check_output("rst_exc_pc", exc_pc, 32'h0);
    check_output("rst_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    $display("[TB] lw with ack three cycles after accept");
    wbq.push_back('{rd: 5'd5, data: 32'hDEAD_BEEF});
    run_access(1'b1, 3'b010, 32'h100, 32'h0, 5'd5, 32'h1000, 2, 32'hDEAD_BEEF,
               1'b0, 1'b0, 32'h100, 4'b1111, 32'h0);
    pop_wb(1);
    next_cycle();
    @(negedge clk);
    check_output("wb_pulse_end", {31'h0, wb_valid}, 32'h0);
    next_cycle();

    $display("[TB] byte and half loads");
    wbq.push_back('{rd: 5'd6, data: 32'hFFFF_FF80});
    run_access(1'b1, 3'b000, 32'h103, 32'h0, 5'd6, 32'h1004, 0, 32'h80FF_FFFF,
               1'b0, 1'b0, 32'h100, 4'b1111, 32'h0);
    pop_wb(1);
    next_cycle();
    wbq.push_back('{rd: 5'd7, data: 32'h0000_0080});
    run_access(1'b1, 3'b100, 32'h103, 32'h0, 5'd7, 32'h1008, 0, 32'h80FF_FFFF,
               1'b0, 1'b0, 32'h100, 4'b1111, 32'h0);
    pop_wb(1);
    next_cycle();
    wbq.push_back('{rd: 5'd8, data: 32'hFFFF_8001});
    run_access(1'b1, 3'b001, 32'h102, 32'h0, 5'd8, 32'h100C, 0, 32'h8001_0000,
               1'b0, 1'b0, 32'h100, 4'b1111, 32'h0);
    pop_wb(1);
    next_cycle();
    wbq.push_back('{rd: 5'd9, data: 32'h0000_8001});
    run_access(1'b1, 3'b101, 32'h102, 32'h0, 5'd9, 32'h1010, 1, 32'h8001_0000,
               1'b0, 1'b0, 32'h100, 4'b1111, 32'h0);
    pop_wb(1);
    next_cycle();

    $display("[TB] stores");
    run_access(1'b0, 3'b000, 32'h201, 32'h1234_5678, 5'd0, 32'h1100, 1, 32'h0,
               1'b0, 1'b0, 32'h200, 4'b0010, 32'h7878_7878);
    @(negedge clk);
    check_output("sb_no_wb", {31'h0, wb_valid}, 32'h0);
    next_cycle();
    run_access(1'b0, 3'b001, 32'h202, 32'h1234_5678, 5'd0, 32'h1104, 0, 32'h0,
               1'b0, 1'b0, 32'h200, 4'b1100, 32'h5678_5678);
    @(negedge clk);
    check_output("sh_no_wb", {31'h0, wb_valid}, 32'h0);
    next_cycle();
    run_access(1'b0, 3'b010, 32'h204, 32'h1234_5678, 5'd0, 32'h1108, 0, 32'h0,
               1'b0, 1'b0, 32'h204, 4'b1111, 32'h1234_5678);
    @(negedge clk);
    check_output("sw_no_wb", {31'h0, wb_valid}, 32'h0);
    next_cycle();

    $display("[TB] misaligned and illegal accesses");
    do_exc(1'b1, 3'b010, 32'h102, 32'h2000, 2'b01);
    do_exc(1'b1, 3'b011, 32'h100, 32'h2004, 2'b10);
    do_exc(1'b0, 3'b101, 32'h101, 32'h2008, 2'b10);
    do_exc(1'b1, 3'b001, 32'h101, 32'h200C, 2'b01);

    $display("[TB] bus timeout");
    apply_stimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd10, 32'h3000, 1'b0);
    @(negedge clk);
    check_output("tmo_accept_stall", {31'h0, stall}, 32'h1);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("tmo_req", {31'h0, dbus_req}, 32'h1);
      check_output("tmo_stall", {31'h0, stall}, {31'h0, (i != 3)});
      next_cycle();
    end
    excq.push_back('{cause: 2'b11, pc: 32'h3000});
    pop_exc(1);
    check_output("tmo_req_drop", {31'h0, dbus_req}, 32'h0);
    check_output("tmo_no_wb", {31'h0, wb_valid}, 32'h0);
    check_output("tmo_stall_free", {31'h0, stall}, 32'h0);
    next_cycle();
    wbq.push_back('{rd: 5'd11, data: 32'hCAFE_F00D});
    run_access(1'b1, 3'b010, 32'h304, 32'h0, 5'd11, 32'h3004, 0, 32'hCAFE_F00D,
               1'b0, 1'b0, 32'h304, 4'b1111, 32'h0);
    pop_wb(1);
    next_cycle();

    $display("[TB] ack while idle");
    dbus_ack   = 1'b1;
    dbus_rdata = 32'h1357_9BDF;
    @(negedge clk);
    check_output("idle_ack_req", {31'h0, dbus_req}, 32'h0);
    next_cycle();
    dbus_ack = 1'b0;
    @(negedge clk);
    check_output("idle_ack_no_wb", {31'h0, wb_valid}, 32'h0);
    next_cycle();

    $display("[TB] flush in idle");
    apply_stimulus(1'b1, 1'b0, 1'b1, 3'b010, 32'h400, 32'hFFFF_0000, 5'd0, 32'h4000, 1'b1);
    @(negedge clk);
    check_output("flush_idle_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    apply_stimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h401, 32'h0, 5'd3, 32'h4004, 1'b1);
    @(negedge clk);
    check_output("flush_idle_req", {31'h0, dbus_req}, 32'h0);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    check_output("flush_idle_no_exc", {31'h0, exc}, 32'h0);
    check_output("flush_idle_req2", {31'h0, dbus_req}, 32'h0);
    next_cycle();

    $display("[TB] flush during REQ");
    wbq.push_back('{rd: 5'd12, data: 32'h55AA_55AA});
    run_access(1'b1, 3'b010, 32'h500, 32'h0, 5'd12, 32'h5000, 1, 32'h55AA_55AA,
               1'b1, 1'b0, 32'h500, 4'b1111, 32'h0);
    pop_wb(1);
    next_cycle();

    $display("[TB] back-to-back loads");
    wbq.push_back('{rd: 5'd13, data: 32'h1111_1111});
    run_access(1'b1, 3'b010, 32'h600, 32'h0, 5'd13, 32'h6000, 0, 32'h1111_1111,
               1'b0, 1'b0, 32'h600, 4'b1111, 32'h0);
    wbq.push_back('{rd: 5'd14, data: 32'h2222_2222});
    run_access(1'b1, 3'b010, 32'h604, 32'h0, 5'd14, 32'h6004, 0, 32'h2222_2222,
               1'b0, 1'b1, 32'h604, 4'b1111, 32'h0);
    pop_wb(1);
    check_output("b2b_gap", last_wb_cycle - prev_wb_cycle, 32'd2);
    next_cycle();

    $display("[TB] reset during REQ");
    apply_stimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h700, 32'h0, 5'd15, 32'h7000, 1'b0);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    check_output("rst_req_before", {31'h0, dbus_req}, 32'h1);
    next_cycle();
    rst_n = 1'b0;
    #1;
    check_output("rst_req_async", {31'h0, dbus_req}, 32'h0);
    check_output("rst_stall_async", {31'h0, stall}, 32'h0);
    next_cycle();
    rst_n      = 1'b1;
    dbus_ack   = 1'b1;
    dbus_rdata = 32'h7777_7777;
    @(negedge clk);
    check_output("rst_after_req", {31'h0, dbus_req}, 32'h0);
    next_cycle();
    dbus_ack = 1'b0;
    @(negedge clk);
    check_output("rst_after_no_wb", {31'h0, wb_valid}, 32'h0);
    check_output("rst_after_no_exc", {31'h0, exc}, 32'h0);
    next_cycle();

    check_output("wbq_empty", wbq.size(), 32'd0);
    check_output("excq_empty", excq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
